// File: rtl/proj_pkg.sv
// Shared types and defaults for the projection bank controller.
package proj_pkg;
  localparam int NCH_DEF     = 3;
  localparam int IN_AW_DEF   = 5;
  localparam int W_AW_DEF    = 10;
  localparam int OUT_AW_DEF  = 7;
  localparam int TMO_W_DEF   = 20;
  localparam int TMO_MAX_DEF = 1000000;

  localparam logic WEB_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/proj_port_mux.sv
// Per-channel SRAM port selector: picks host, core or readback source by phase.
module proj_port_mux
  import proj_pkg::*;
#(
  parameter int IN_AW  = IN_AW_DEF,
  parameter int W_AW   = W_AW_DEF,
  parameter int OUT_AW = OUT_AW_DEF,
  parameter int CH_W   = 2
) (
  input  logic              i_force_idle,
  input  state_t            i_state,
  input  logic [CH_W-1:0]   i_ch_idx,
  input  logic [CH_W-1:0]   i_host_ch,
  input  logic              i_host_bcast,
  input  logic [IN_AW-1:0]  i_host_in_addr,
  input  logic              i_host_in_web,
  input  logic [W_AW-1:0]   i_host_w_addr,
  input  logic              i_host_w_web,
  input  logic [OUT_AW-1:0] i_host_out_addr,
  input  logic              i_host_out_web,
  input  logic [OUT_AW-1:0] i_rd_addr,
  input  logic [IN_AW-1:0]  i_core_in_addr,
  input  logic              i_core_in_web,
  input  logic [W_AW-1:0]   i_core_w_addr,
  input  logic              i_core_w_web,
  input  logic [OUT_AW-1:0] i_core_out_addr,
  input  logic              i_core_out_web,
  output logic [IN_AW-1:0]  o_in_a,
  output logic              o_in_web,
  output logic [W_AW-1:0]   o_w_a,
  output logic              o_w_web,
  output logic [OUT_AW-1:0] o_out_a,
  output logic              o_out_web
);
  logic w_sel;
  assign w_sel = (i_host_ch == i_ch_idx);

  always_comb begin
    o_in_a    = '0;
    o_in_web  = WEB_IDLE;
    o_w_a     = '0;
    o_w_web   = WEB_IDLE;
    o_out_a   = '0;
    o_out_web = WEB_IDLE;
    if (!i_force_idle) begin
      case (i_state)
        ST_LOAD: begin
          // Broadcast only widens the input path; weights stay per-channel.
          if (w_sel || i_host_bcast) begin
            o_in_a   = i_host_in_addr;
            o_in_web = i_host_in_web;
          end
          if (w_sel) begin
            o_w_a   = i_host_w_addr;
            o_w_web = i_host_w_web;
          end
        end
        ST_RUN: begin
          o_in_a    = i_core_in_addr;
          o_in_web  = i_core_in_web;
          o_w_a     = i_core_w_addr;
          o_w_web   = i_core_w_web;
          o_out_a   = i_core_out_addr;
          o_out_web = i_core_out_web;
        end
        ST_DONE: o_out_a = i_rd_addr;
        ST_DRAIN: begin
          if (w_sel) begin
            o_out_a   = i_host_out_addr;
            o_out_web = i_host_out_web;
          end else begin
            o_out_a = i_rd_addr;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/proj_bank_ctrl.sv
// Phase sequencer (load/run/done/drain) and SRAM port mux for NCH projection cores.
module proj_bank_ctrl
  import proj_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int IN_AW   = IN_AW_DEF,
  parameter int W_AW    = W_AW_DEF,
  parameter int OUT_AW  = OUT_AW_DEF,
  parameter int TMO_W   = TMO_W_DEF,
  parameter int TMO_MAX = TMO_MAX_DEF,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_load_req,
  input  logic                         i_drain_req,
  input  logic [CH_W-1:0]              i_host_ch,
  input  logic                         i_host_bcast,
  input  logic [IN_AW-1:0]             i_host_in_addr,
  input  logic                         i_host_in_web,
  input  logic [W_AW-1:0]              i_host_w_addr,
  input  logic                         i_host_w_web,
  input  logic [OUT_AW-1:0]            i_host_out_addr,
  input  logic                         i_host_out_web,
  input  logic [NCH-1:0][OUT_AW-1:0]   i_rd_addr,
  input  logic [NCH-1:0]               i_core_finished,
  input  logic [NCH-1:0][IN_AW-1:0]    i_core_in_addr,
  input  logic [NCH-1:0][W_AW-1:0]     i_core_w_addr,
  input  logic [NCH-1:0][OUT_AW-1:0]   i_core_out_addr,
  input  logic [NCH-1:0]               i_core_in_web,
  input  logic [NCH-1:0]               i_core_w_web,
  input  logic [NCH-1:0]               i_core_out_web,
  output logic [NCH-1:0]               o_core_en,
  output logic [NCH-1:0][IN_AW-1:0]    o_in_mem_a,
  output logic [NCH-1:0][W_AW-1:0]     o_w_mem_a,
  output logic [NCH-1:0][OUT_AW-1:0]   o_out_mem_a,
  output logic [NCH-1:0]               o_in_mem_web,
  output logic [NCH-1:0]               o_w_mem_web,
  output logic [NCH-1:0]               o_out_mem_web,
  output logic [2:0]                   o_state,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err_timeout,
  output logic [NCH-1:0]               o_fin_mask,
  output logic [TMO_W-1:0]             o_cycle_cnt
);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_t           r_state, w_state_nxt;
  logic [NCH-1:0]   r_fin_mask, w_fin_nxt;
  logic [TMO_W-1:0] r_cycle_cnt;
  logic             r_err_timeout;
  logic             w_all_fin, w_tmo_hit;

  assign w_fin_nxt = r_fin_mask | i_core_finished;
  assign w_all_fin = &w_fin_nxt;
  assign w_tmo_hit = (r_cycle_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_nxt = i_load_req ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (i_start)          w_state_nxt = ST_RUN;
        else if (!i_load_req) w_state_nxt = ST_IDLE;
        else                  w_state_nxt = ST_LOAD;
      end
      ST_RUN:   w_state_nxt = (w_all_fin || w_tmo_hit) ? ST_DONE : ST_RUN;
      ST_DONE: begin
        if (i_drain_req)     w_state_nxt = ST_DRAIN;
        else if (i_load_req) w_state_nxt = ST_LOAD;
        else                 w_state_nxt = ST_DONE;
      end
      ST_DRAIN: w_state_nxt = i_drain_req ? ST_DRAIN : ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_state   = r_state;
    o_busy    = (r_state == ST_RUN);
    o_done    = (r_state == ST_DONE);
    o_core_en = {NCH{r_state == ST_RUN}};
  end

  // Completion beats timeout when both land on the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fin_mask    <= '0;
      r_cycle_cnt   <= '0;
      r_err_timeout <= 1'b0;
    end else if (r_state == ST_LOAD && i_start) begin
      r_fin_mask    <= '0;
      r_cycle_cnt   <= '0;
      r_err_timeout <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_fin_mask <= w_fin_nxt;
      if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (!w_all_fin && w_tmo_hit) r_err_timeout <= 1'b1;
    end
  end

  assign o_fin_mask    = r_fin_mask;
  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_err_timeout = r_err_timeout;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    proj_port_mux #(
      .IN_AW(IN_AW), .W_AW(W_AW), .OUT_AW(OUT_AW), .CH_W(CH_W)
    ) u_mux (
      .i_force_idle    (!rst),
      .i_state         (r_state),
      .i_ch_idx        (CH_W'(g)),
      .i_host_ch       (i_host_ch),
      .i_host_bcast    (i_host_bcast),
      .i_host_in_addr  (i_host_in_addr),
      .i_host_in_web   (i_host_in_web),
      .i_host_w_addr   (i_host_w_addr),
      .i_host_w_web    (i_host_w_web),
      .i_host_out_addr (i_host_out_addr),
      .i_host_out_web  (i_host_out_web),
      .i_rd_addr       (i_rd_addr[g]),
      .i_core_in_addr  (i_core_in_addr[g]),
      .i_core_in_web   (i_core_in_web[g]),
      .i_core_w_addr   (i_core_w_addr[g]),
      .i_core_w_web    (i_core_w_web[g]),
      .i_core_out_addr (i_core_out_addr[g]),
      .i_core_out_web  (i_core_out_web[g]),
      .o_in_a          (o_in_mem_a[g]),
      .o_in_web        (o_in_mem_web[g]),
      .o_w_a           (o_w_mem_a[g]),
      .o_w_web         (o_w_mem_web[g]),
      .o_out_a         (o_out_mem_a[g]),
      .o_out_web       (o_out_mem_web[g])
    );
  end
endmodule
